key_dispatcher: RTL and testbench
=================================

# key_dispatcher

Upstream stage of the multi-core RC4 key search. It issues candidate secret keys one at a time from a shared incrementing counter to the N decryption cores over a request/grant handshake, using round-robin arbitration. It halts when the master state controller asserts `stop` (a core found the key) or when the key space is exhausted. It replaces the fixed per-core key ranges, so a core that finishes early immediately takes more work.

## Interface
- `NUM_CORES`, 4: number of requesting cores (2..8)
- `KEY_WIDTH`, 24: width of issued key
- `KEY_MAX`, 24'h3FFFFF: last key issued; must be < 2^KEY_WIDTH

- `clk`  in  1: system clock; the block's only clock
- `reset_n`  in  1: asynchronous, active-low reset
- `start`  in  1: one-cycle pulse; begins dispatch from IDLE
- `stop`  in  1: level; a core succeeded, halt all dispatch
- `key_req`  in  NUM_CORES: per-core request, held high until granted
- `key_grant`  out  NUM_CORES: one-hot, one-cycle pulse; core i takes `key_out` this cycle
- `key_out`  out  KEY_WIDTH: key for the granted core; held until the next grant
- `keys_issued`  out  KEY_WIDTH+1: count of keys granted so far
- `busy`  out  1: high in DISPATCH
- `exhausted`  out  1: all keys 0..KEY_MAX issued (sticky)
- `stopped`  out  1: halted by `stop` (sticky)

## Operation
- States: IDLE, DISPATCH, EXHAUSTED, STOPPED.
- Transition priority: `stop` beats everything. In any state except EXHAUSTED, `stop`=1 moves the block to STOPPED on the next edge, and no grant is issued in that cycle.
- IDLE: moves to DISPATCH on `start`. Requests are ignored.
- DISPATCH:
  - Each cycle, the arbiter picks at most one requester.
  - Search order: round-robin starting at index (last_granted+1) mod NUM_CORES. After reset, last_granted = NUM_CORES-1, so core 0 has first priority.
  - A core granted in cycle t is masked in cycle t+1. This tolerates the one-cycle lag of its registered `key_req` deassert.
  - On a grant: `key_out` ← next_key, `key_grant[i]` pulses, next_key += 1, `keys_issued` += 1, last_granted ← i.
  - Issuing key == KEY_MAX moves the block to EXHAUSTED on the same edge. That grant still completes.
- EXHAUSTED: `exhausted`=1 and no further grants. `stop` is ignored, so `stopped` stays 0. The top level separately ANDs the cores' failure flags.
- STOPPED: `stopped`=1 and no grants. `start` is ignored.
- The block leaves EXHAUSTED or STOPPED only through `reset_n`.
- Width rules:
  - next_key and `keys_issued` are KEY_WIDTH+1 bits and never wrap. The maximum value of `keys_issued` is KEY_MAX+1.
  - `key_out` is next_key[KEY_WIDTH-1:0].
- A `key_req` bit that drops before being granted is simply not served. No key is lost, because keys advance only on a grant.

## Timing
- Reset values (asynchronous): state IDLE, `key_grant`=0, `key_out`=0, `keys_issued`=0, `busy`=0, `exhausted`=0, `stopped`=0, next_key=0, last_granted=NUM_CORES-1.
- All outputs are registered.
- Latency:
  - `key_req` sampled high at edge t produces `key_grant` high after edge t (earliest) and low after edge t+1.
  - `start` at edge t puts the block in DISPATCH after t. The first possible grant is after edge t+1.
- Throughput: one key per cycle when at least two cores are requesting. A single requester is served every other cycle because of the mask.
- `stop` sampled at edge t: no grant after edge t, and `stopped`=1 and `busy`=0 after edge t.
- `start` and `stop` asserted in the same cycle: the block goes to STOPPED.
- `reset_n` asserted mid-grant: the grant pulse clears immediately (asynchronously). The counter returns to 0.

## Test plan
- Reset, `start`, core 0 alone holds `key_req` (KEY_MAX=7) -> grants on alternate cycles with `key_out` 0,1,2…7; `exhausted`=1 after key 7; `keys_issued`=8; no further grants.
- All 4 cores request continuously (KEY_MAX=7) -> grant order cores 0,1,2,3,0,1,2,3 with `key_out` 0..7, one grant per cycle, never the same core on consecutive cycles.
- Cores 1 and 3 request, last_granted=3 -> core 1 is granted first, then core 3; cores 0 and 2 are never granted.
- `stop` raised while 4 cores request after 5 grants -> no grant in the `stop` cycle or later; `stopped`=1; `keys_issued`=5; `key_out` holds 4; a later `start` has no effect.
- `start` and `stop` pulsed in the same cycle from IDLE -> STOPPED; zero grants. Separately, `stop` in EXHAUSTED -> `stopped` stays 0.
- `reset_n` low during DISPATCH with `key_out`=3 -> all outputs return to reset values at once; after re-`start`, the first grant has `key_out`=0 and goes to core 0.

Source files
------------

// File: rtl/key_dispatcher.sv
// key_dispatcher: hands out candidate RC4 keys one at a time from a shared
// counter to NUM_CORES decryption cores. Requests are served round-robin.
// Dispatch halts when a core reports success (stop) or when the key space
// 0..KEY_MAX has been fully issued.
module key_dispatcher #(
    parameter int                   NUM_CORES = 4,
    parameter int                   KEY_WIDTH = 24,
    parameter logic [KEY_WIDTH-1:0] KEY_MAX   = 24'h3FFFFF
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 stop,
    input  logic [NUM_CORES-1:0] key_req,
    output logic [NUM_CORES-1:0] key_grant,
    output logic [KEY_WIDTH-1:0] key_out,
    output logic [KEY_WIDTH:0]   keys_issued,
    output logic                 busy,
    output logic                 exhausted,
    output logic                 stopped
);

    localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_DISPATCH  = 2'd1;
    localparam logic [1:0] ST_EXHAUSTED = 2'd2;
    localparam logic [1:0] ST_STOPPED   = 2'd3;

    // The last key is compared at counter width so the counter never wraps.
    localparam logic [KEY_WIDTH:0] LAST_KEY = {1'b0, KEY_MAX};

    logic [1:0]           state;
    logic [KEY_WIDTH:0]   next_key;
    logic [IDX_W-1:0]     last_granted;

    logic [NUM_CORES-1:0] eligible;
    logic [NUM_CORES-1:0] grant_vec;
    logic [IDX_W-1:0]     pick;
    logic [IDX_W-1:0]     cand_idx;
    logic                 found;
    int                   cand;

    // keys_issued always tracks next_key since both advance only on a grant.
    assign keys_issued = next_key;

    // Round-robin pick starting after the last granted core. The core granted
    // last cycle is masked because its request drop lags by one cycle.
    always_comb begin
        eligible  = key_req & ~key_grant;
        found     = 1'b0;
        pick      = '0;
        cand      = 0;
        cand_idx  = '0;
        grant_vec = '0;
        for (int k = 1; k <= NUM_CORES; k++) begin
            cand     = (int'(last_granted) + k) % NUM_CORES;
            cand_idx = IDX_W'(cand);
            if (!found && eligible[cand_idx]) begin
                found = 1'b1;
                pick  = cand_idx;
            end
        end
        if (found) begin
            grant_vec[pick] = 1'b1;
        end
    end

    // Control state, counter and registered outputs; stop overrides all but
    // the exhausted state, and the terminal states are left only via reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            key_grant    <= '0;
            key_out      <= '0;
            next_key     <= '0;
            last_granted <= IDX_W'(NUM_CORES - 1);
            busy         <= 1'b0;
            exhausted    <= 1'b0;
            stopped      <= 1'b0;
        end else begin
            key_grant <= '0;
            if (stop && (state != ST_EXHAUSTED)) begin
                state   <= ST_STOPPED;
                busy    <= 1'b0;
                stopped <= 1'b1;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            state <= ST_DISPATCH;
                            busy  <= 1'b1;
                        end
                    end
                    ST_DISPATCH: begin
                        if (found) begin
                            key_grant    <= grant_vec;
                            key_out      <= next_key[KEY_WIDTH-1:0];
                            next_key     <= next_key + 1'b1;
                            last_granted <= pick;
                            if (next_key == LAST_KEY) begin
                                state     <= ST_EXHAUSTED;
                                busy      <= 1'b0;
                                exhausted <= 1'b1;
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_key_dispatcher.sv
// Self-checking bench for key_dispatcher with a behavioural reference model.
module tb_key_dispatcher;

    localparam int NC   = 4;
    localparam int KW   = 8;
    localparam int KMAX = 7;

    logic          clk;
    logic          reset_n;
    logic          start;
    logic          stop;
    logic [NC-1:0] key_req;
    logic [NC-1:0] key_grant;
    logic [KW-1:0] key_out;
    logic [KW:0]   keys_issued;
    logic          busy;
    logic          exhausted;
    logic          stopped;

    int checks = 0;
    int passes = 0;

    // Reference model: mode 0 idle, 1 dispatching, 2 exhausted, 3 stopped
    int          m_mode;
    int          m_last;
    int          m_next;
    int          m_key;
    logic [NC-1:0] m_grant;
    logic [NC-1:0] m_prev;

    key_dispatcher #(.NUM_CORES(NC), .KEY_WIDTH(KW), .KEY_MAX(8'd7)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .stop(stop),
        .key_req(key_req), .key_grant(key_grant), .key_out(key_out),
        .keys_issued(keys_issued), .busy(busy), .exhausted(exhausted),
        .stopped(stopped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    wire [23:0] obs = {key_grant, key_out, keys_issued, busy, exhausted, stopped};

    function automatic logic [23:0] exp_vec();
        return {m_grant, 8'(m_key), 9'(m_next), m_mode == 1, m_mode == 2, m_mode == 3};
    endfunction

    task automatic model_reset();
        m_mode  = 0;
        m_last  = NC - 1;
        m_next  = 0;
        m_key   = 0;
        m_grant = '0;
        m_prev  = '0;
    endtask

    // Apply the dispatch rules to the inputs present at the coming edge.
    task automatic model_edge();
        logic [NC-1:0] elig;
        int            idx;
        m_grant = '0;
        if (stop && m_mode != 2) begin
            m_mode = 3;
        end else if (m_mode == 0) begin
            if (start) m_mode = 1;
        end else if (m_mode == 1) begin
            elig = key_req & ~m_prev;
            for (int k = 1; k <= NC; k++) begin
                idx = (m_last + k) % NC;
                if (m_grant == '0 && elig[idx]) begin
                    m_grant[idx] = 1'b1;
                    m_key  = m_next;
                    m_next = m_next + 1;
                    m_last = idx;
                    if (m_key == KMAX) m_mode = 2;
                end
            end
        end
        m_prev = m_grant;
    endtask

    task automatic cycle(input logic s, input logic p, input logic [NC-1:0] r);
        start   = s;
        stop    = p;
        key_req = r;
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        start   = 1'b0;
        stop    = 1'b0;
        key_req = '0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (obs !== 24'h0) $display("[TB] FAIL reset: got %h expected %h", obs, 24'h0);
        else passes++;
    endtask

    task automatic test_single_core();
        do_reset();
        cycle(1'b1, 1'b0, 4'b0000);
        for (int c = 0; c < 20; c++) begin
            cycle(1'b0, 1'b0, 4'b0001);
            checks++;
            if (obs !== exp_vec()) $display("[TB] FAIL single_core c%0d: got %h expected %h", c, obs, exp_vec());
            else passes++;
        end
        checks++;
        if (keys_issued !== 9'd8 || exhausted !== 1'b1)
            $display("[TB] FAIL single_core_end: got issued=%0d exh=%b expected 8 1", keys_issued, exhausted);
        else passes++;
    endtask

    task automatic test_all_cores();
        do_reset();
        cycle(1'b1, 1'b0, 4'b1111);
        for (int c = 0; c < 10; c++) begin
            cycle(1'b0, 1'b0, 4'b1111);
            checks++;
            if (obs !== exp_vec()) $display("[TB] FAIL all_cores c%0d: got %h expected %h", c, obs, exp_vec());
            else passes++;
        end
    endtask

    task automatic test_sparse();
        do_reset();
        cycle(1'b1, 1'b0, 4'b1010);
        for (int c = 0; c < 18; c++) begin
            cycle(1'b0, 1'b0, 4'b1010);
            checks++;
            if (obs !== exp_vec()) $display("[TB] FAIL sparse c%0d: got %h expected %h", c, obs, exp_vec());
            else passes++;
        end
    endtask

    task automatic test_stop();
        do_reset();
        cycle(1'b1, 1'b0, 4'b1111);
        for (int c = 0; c < 5; c++) cycle(1'b0, 1'b0, 4'b1111);
        for (int c = 0; c < 5; c++) begin
            cycle(c == 3, c < 2, 4'b1111);
            checks++;
            if (obs !== exp_vec()) $display("[TB] FAIL stop c%0d: got %h expected %h", c, obs, exp_vec());
            else passes++;
        end
        checks++;
        if (keys_issued !== 9'd5 || key_out !== 8'd4 || stopped !== 1'b1)
            $display("[TB] FAIL stop_end: got issued=%0d key=%0d stopped=%b expected 5 4 1",
                     keys_issued, key_out, stopped);
        else passes++;
    endtask

    task automatic test_start_stop_same();
        do_reset();
        cycle(1'b1, 1'b1, 4'b1111);
        for (int c = 0; c < 3; c++) begin
            cycle(1'b0, 1'b0, 4'b1111);
            checks++;
            if (obs !== exp_vec()) $display("[TB] FAIL start_stop c%0d: got %h expected %h", c, obs, exp_vec());
            else passes++;
        end
        do_reset();
        cycle(1'b1, 1'b0, 4'b1111);
        for (int c = 0; c < 9; c++) cycle(1'b0, 1'b0, 4'b1111);
        for (int c = 0; c < 3; c++) begin
            cycle(1'b0, 1'b1, 4'b1111);
            checks++;
            if (obs !== exp_vec()) $display("[TB] FAIL stop_in_exh c%0d: got %h expected %h", c, obs, exp_vec());
            else passes++;
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        cycle(1'b1, 1'b0, 4'b1111);
        for (int c = 0; c < 4; c++) cycle(1'b0, 1'b0, 4'b1111);
        checks++;
        if (key_out !== 8'd3 || key_grant !== 4'b1000)
            $display("[TB] FAIL pre_reset: got key=%0d grant=%b expected 3 1000", key_out, key_grant);
        else passes++;
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (obs !== exp_vec()) $display("[TB] FAIL async_reset: got %h expected %h", obs, exp_vec());
        else passes++;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        cycle(1'b1, 1'b0, 4'b1111);
        for (int c = 0; c < 3; c++) begin
            cycle(1'b0, 1'b0, 4'b1111);
            checks++;
            if (obs !== exp_vec()) $display("[TB] FAIL after_reset c%0d: got %h expected %h", c, obs, exp_vec());
            else passes++;
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 8; r++) begin
            do_reset();
            for (int c = 0; c < 30; c++) begin
                cycle(c == 0 || $urandom_range(0, 9) == 0, $urandom_range(0, 59) == 0,
                      4'($urandom_range(0, 15)));
                checks++;
                if (obs !== exp_vec()) $display("[TB] FAIL random r%0d c%0d: got %h expected %h", r, c, obs, exp_vec());
                else passes++;
            end
        end
    endtask

    initial begin
        reset_n = 1'b1;
        start   = 1'b0;
        stop    = 1'b0;
        key_req = '0;
        model_reset();
        #2;
        test_reset();
        test_single_core();
        test_all_cores();
        test_sparse();
        test_stop();
        test_start_stop_same();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
